// File: rtl/pcm_mem_ctrl_if.sv
// Request/response and PCM array signals of pcm_mem_ctrl.
// The controller connects through the slave modport; the upstream agent and array model use master.
interface pcm_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [19:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_byteen;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        busy;
  logic        pcm_ce;
  logic        pcm_we;
  logic [19:0] pcm_addr;
  logic [15:0] pcm_wdata;
  logic [15:0] pcm_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_byteen, pcm_rdata,
    output req_ready, rsp_valid, rsp_rdata, busy, pcm_ce, pcm_we, pcm_addr, pcm_wdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_byteen, pcm_rdata,
    input  req_ready, rsp_valid, rsp_rdata, busy, pcm_ce, pcm_we, pcm_addr, pcm_wdata
  );
endinterface

// File: rtl/pcm_mem_ctrl.sv
// Single-request PCM array controller: timed read, write and read-modify-write phases.
// Partial writes read the word first and merge it with the enabled bytes.
module pcm_mem_ctrl #(
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 8,
  parameter int RECOVER   = 1
) (
  input  logic           clk,
  input  logic           reset,
  pcm_mem_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, REC, RESP} state_t;

  localparam logic [7:0] RD_LEN  = 8'(READ_LAT - 1);
  localparam logic [7:0] WR_LEN  = 8'(WRITE_LAT - 1);
  localparam logic [7:0] REC_LEN = 8'(RECOVER - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        write_q;
  logic [19:0] addr_q;
  logic [15:0] wdata_q, rdata_q;
  logic [1:0]  byteen_q;
  logic        accept, last;
  logic [15:0] merged;

  assign accept = bus.req_valid && (state_q == IDLE);
  assign last   = (cnt_q == 8'd0);
  assign merged = {byteen_q[1] ? wdata_q[15:8] : bus.pcm_rdata[15:8],
                   byteen_q[0] ? wdata_q[7:0]  : bus.pcm_rdata[7:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (accept) begin
          if (!bus.req_write) begin
            state_d = RD;
            cnt_d   = RD_LEN;
          end else begin
            case (bus.req_byteen)
              2'b11:   begin state_d = WR;     cnt_d = WR_LEN; end
              2'b00:   begin state_d = RESP;   cnt_d = 8'd0;   end
              default: begin state_d = RMW_RD; cnt_d = RD_LEN; end
            endcase
          end
        end
      end
      RD: begin
        if (last) state_d = RESP;
        else      cnt_d   = cnt_q - 8'd1;
      end
      RMW_RD: begin
        if (last) begin
          state_d = WR;
          cnt_d   = WR_LEN;
        end else cnt_d = cnt_q - 8'd1;
      end
      WR: begin
        if (last) begin
          if (RECOVER > 0) begin
            state_d = REC;
            cnt_d   = REC_LEN;
          end else state_d = RESP;
        end else cnt_d = cnt_q - 8'd1;
      end
      REC: begin
        if (last) state_d = RESP;
        else      cnt_d   = cnt_q - 8'd1;
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      byteen_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        write_q  <= bus.req_write;
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        byteen_q <= bus.req_byteen;
      end
      if (state_q == RD && last)     rdata_q <= bus.pcm_rdata;
      // wdata_q becomes the merged word so WR drives it unchanged for its whole pulse
      if (state_q == RMW_RD && last) wdata_q <= merged;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = (state_q == RESP && !write_q) ? rdata_q : 16'd0;
  assign bus.pcm_ce    = (state_q == RD) || (state_q == RMW_RD) || (state_q == WR);
  assign bus.pcm_we    = (state_q == WR);
  assign bus.pcm_addr  = (state_q == IDLE) ? 20'd0 : addr_q;
  assign bus.pcm_wdata = (state_q == IDLE) ? 16'd0 : wdata_q;

endmodule

// File: tb/tb_pcm_mem_ctrl.sv
// Directed bench for pcm_mem_ctrl with default timing (READ_LAT=2, WRITE_LAT=8, RECOVER=1).
module tb_pcm_mem_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  pcm_mem_ctrl_if bus ();

  pcm_mem_ctrl #(.READ_LAT(2), .WRITE_LAT(8), .RECOVER(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        write;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [1:0]  byteen;
    logic [15:0] array_word;
    int          exp_lat;
    logic [15:0] exp_rdata;
    int          exp_ce;
    int          exp_we;
    logic [15:0] exp_wr_data;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat = 0, ce_n = 0, we_n = 0, bad_addr = 0, bad_data = 0, bad_ready = 0;
    logic [15:0] rd = 16'hxxxx;
    @(negedge clk);
    chk({v.name, " ready_before"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_write  = v.write;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    bus.req_byteen = v.byteen;
    bus.pcm_rdata  = v.array_word;
    @(posedge clk);
    #1;
    // scramble request inputs: the controller must work from its captured copy
    bus.req_valid  = 1'b0;
    bus.req_write  = ~v.write;
    bus.req_addr   = ~v.addr;
    bus.req_wdata  = ~v.wdata;
    bus.req_byteen = ~v.byteen;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (bus.req_ready) bad_ready++;
      if (bus.pcm_ce) begin
        ce_n++;
        if (bus.pcm_addr !== v.addr) bad_addr++;
      end
      if (bus.pcm_we) begin
        we_n++;
        if (bus.pcm_wdata !== v.exp_wr_data) bad_data++;
      end
      if (bus.rsp_valid) begin
        lat = cyc;
        rd  = bus.rsp_rdata;
        break;
      end
    end
    chk({v.name, " latency"},    32'(lat), 32'(v.exp_lat));
    chk({v.name, " rsp_rdata"},  32'(rd), 32'(v.exp_rdata));
    chk({v.name, " ce_cycles"},  32'(ce_n), 32'(v.exp_ce));
    chk({v.name, " we_cycles"},  32'(we_n), 32'(v.exp_we));
    chk({v.name, " bad_addr"},   32'(bad_addr), 32'd0);
    chk({v.name, " bad_wdata"},  32'(bad_data), 32'd0);
    chk({v.name, " ready_busy"}, 32'(bad_ready), 32'd0);
  endtask

  initial begin
    int r1, r2, bad_ready, rsp_seen;
    vecs[0] = '{"read",      1'b0, 20'h00010, 16'h0000, 2'b11, 16'hBEEF,  3, 16'hBEEF,  2, 0, 16'h0000};
    vecs[1] = '{"full_wr",   1'b1, 20'hFFFFF, 16'h1234, 2'b11, 16'h0000, 10, 16'h0000,  8, 8, 16'h1234};
    vecs[2] = '{"part_wr01", 1'b1, 20'h00400, 16'hAA55, 2'b01, 16'h1234, 12, 16'h0000, 10, 8, 16'h1255};
    vecs[3] = '{"part_wr10", 1'b1, 20'h80001, 16'hAA55, 2'b10, 16'h1234, 12, 16'h0000, 10, 8, 16'hAA34};
    vecs[4] = '{"wr_be00",   1'b1, 20'h12345, 16'hFFFF, 2'b00, 16'h7777,  1, 16'h0000,  0, 0, 16'h0000};
    vecs[5] = '{"read2",     1'b0, 20'hABCDE, 16'h0000, 2'b00, 16'h5A5A,  3, 16'h5A5A,  2, 0, 16'h0000};

    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_byteen = '0;
    bus.pcm_rdata  = '0;

    // reset state
    #2;
    chk("rst_ready",  32'(bus.req_ready), 32'd1);
    chk("rst_rsp",    32'({bus.rsp_valid, bus.rsp_rdata}), 32'd0);
    chk("rst_busy",   32'(bus.busy), 32'd0);
    chk("rst_pcm",    32'({bus.pcm_ce, bus.pcm_we}), 32'd0);
    chk("rst_paddr",  32'(bus.pcm_addr), 32'd0);
    chk("rst_pwdata", 32'(bus.pcm_wdata), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // back-to-back reads with req_valid held through RESP
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_addr   = 20'h00020;
    bus.req_byteen = 2'b11;
    bus.pcm_rdata  = 16'h1111;
    @(posedge clk);
    r1 = 0; bad_ready = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (bus.req_ready) bad_ready++;
      if (bus.rsp_valid) begin r1 = cyc; break; end
    end
    chk("b2b first_lat", 32'(r1), 32'd3);
    chk("b2b ready_low", 32'(bad_ready), 32'd0);
    @(negedge clk);
    chk("b2b idle_after_resp", 32'(bus.req_ready), 32'd1);
    bus.pcm_rdata = 16'h2222;
    @(negedge clk);
    chk("b2b second_accept", 32'({bus.busy, bus.pcm_ce}), 32'd3);
    r2 = 0;
    for (int cyc = 2; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin r2 = cyc; break; end
    end
    bus.req_valid = 1'b0;
    chk("b2b second_lat",   32'(r2), 32'd3);
    chk("b2b second_rdata", 32'(bus.rsp_rdata), 32'h2222);

    // reset asserted in the 4th WR cycle of a full write
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_addr   = 20'h00333;
    bus.req_wdata  = 16'hCAFE;
    bus.req_byteen = 2'b11;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_wr in_wr", 32'(bus.pcm_we), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("rst_wr we_drop", 32'({bus.pcm_ce, bus.pcm_we}), 32'd0);
    chk("rst_wr ready",   32'(bus.req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    rsp_seen = 0; bad_ready = 0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(negedge clk);
      if (bus.rsp_valid) rsp_seen++;
      if (!bus.req_ready || bus.pcm_we) bad_ready++;
    end
    chk("rst_wr no_rsp",     32'(rsp_seen), 32'd0);
    chk("rst_wr idle_after", 32'(bad_ready), 32'd0);

    // controller is usable right after reset
    run_vec(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pcm_mem_ctrl.md
PCM_MEM_CTRL -- requirements
Module: pcm_mem_ctrl

Interface
REQ-001 Parameter READ_LAT, default 2, PCM array read access cycles (legal 1..255).
REQ-002 Parameter WRITE_LAT, default 8, PCM array write pulse cycles (legal 1..255).
REQ-003 Parameter RECOVER, default 1, idle cycles after a write pulse (legal 0..255).
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 req_valid  input  1  upstream request present.
REQ-007 req_ready  output  1  controller can accept a request this cycle.
REQ-008 req_write  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  20  word address.
REQ-010 req_wdata  input  16  write data.
REQ-011 req_byteen  input  2  byte enables; bit1 = [15:8], bit0 = [7:0].
REQ-012 rsp_valid  output  1  one-cycle completion pulse.
REQ-013 rsp_rdata  output  16  read data; 0 for writes.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 pcm_ce  output  1  array chip enable.
REQ-016 pcm_we  output  1  array write strobe.
REQ-017 pcm_addr  output  20  array address.
REQ-018 pcm_wdata  output  16  array write data.
REQ-019 pcm_rdata  input  16  array read data, valid in last cycle of a read access.

Function
REQ-020 Accept on the rising edge where req_valid=1 and req_ready=1; req_ready = 1 only in IDLE.
REQ-021 On accept, capture req_write, req_addr, req_wdata and req_byteen into internal registers; inputs are ignored until the next accept.
REQ-022 FSM states: IDLE, RD, RMW_RD, WR, REC, RESP.
REQ-023 IDLE transitions on accept:
- read -> RD
- write with byteen=11 -> WR
- write with byteen 01/10 -> RMW_RD
- write with byteen=00 -> RESP; no array access.
REQ-024 RD and RMW_RD last exactly READ_LAT cycles with pcm_ce=1, pcm_we=0 and pcm_addr = captured address.
REQ-025 Sample pcm_rdata on the final RD/RMW_RD edge.
REQ-026 RD is followed by RESP.
REQ-027 RMW_RD is followed by WR with the merged word: enabled bytes from captured wdata, disabled bytes from sampled pcm_rdata.
REQ-028 WR lasts exactly WRITE_LAT cycles.
REQ-029 During WR: pcm_ce=1, pcm_we=1, and pcm_addr/pcm_wdata held stable.
REQ-030 WR is followed by REC if RECOVER>0, else RESP.
REQ-031 REC lasts RECOVER cycles with pcm_ce=0 and pcm_we=0, then goes to RESP.
REQ-032 RESP lasts one cycle with rsp_valid=1, then returns to IDLE.
- rsp_rdata = sampled word for reads; 0 for writes.
REQ-033 Outside RD/RMW_RD/WR, pcm_ce=0 and pcm_we=0; pcm_addr/pcm_wdata are 0 in IDLE.
REQ-034 Phase counter is 8 bits; it loads the phase length minus 1 on state entry and exits the state at 0.
REQ-035 Latency from accept edge to the rsp_valid cycle:
- read: READ_LAT+1
- full write: WRITE_LAT+RECOVER+1
- partial write: READ_LAT+WRITE_LAT+RECOVER+1
- byteen=00: 1
REQ-036 A request held valid during RESP is not accepted; it is accepted in the following IDLE cycle.

Reset
REQ-037 Reset asserted -> immediately:
- state IDLE, counter 0
- req_ready=1
- rsp_valid=0, rsp_rdata=0
- busy=0
- pcm_ce=0, pcm_we=0, pcm_addr=0, pcm_wdata=0
REQ-038 Reset mid-operation (including mid-WR) aborts the operation with no response; pcm_we drops asynchronously.
REQ-039 After reset release, the first rising edge may accept a request.

Verification
REQ-040 Defaults; read addr 0x00010, array returns 0xBEEF -> pcm_ce high 2 cycles, rsp_valid at accept+3, rsp_rdata=0xBEEF.
REQ-041 Full write addr 0xFFFFF data 0x1234 byteen 11 -> pcm_we high 8 cycles with addr 0xFFFFF/data 0x1234, REC 1 cycle, rsp_valid at accept+10, rsp_rdata=0.
REQ-042 Partial write data 0xAA55 byteen 01, array holds 0x1234 -> 2-cycle read, then write of 0x1255; rsp_valid at accept+12.
REQ-043 Write byteen 00 -> no pcm_ce activity, rsp_valid at accept+1.
REQ-044 req_valid held high for two back-to-back reads -> second accept on the IDLE cycle after RESP; req_ready=0 from accept through RESP.
REQ-045 Reset asserted in the 4th WR cycle -> pcm_we=0 immediately, no rsp_valid, req_ready=1 after release.
